// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order {PC, instruction} queue between fetch and decode
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   i_in_valid   fetch presents a pair
//   i_in_pc      PC of fetched instruction
//   i_in_instr   fetched instruction word
//   o_in_ready   queue has space; drives fetch PC write enable
//   i_flush      discard all entries and this cycle's push
//   o_out_valid  head entry valid
//   o_out_pc     head PC (0 when empty)
//   o_out_instr  head instruction (0 when empty)
//   i_out_ready  decode takes head entry
//   o_count      occupied entries, 0..DEPTH
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic [XLEN-1:0] i_in_instr,
  output logic            o_in_ready,
  input  logic            i_flush,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_instr,
  input  logic            i_out_ready,
  output logic [AW:0]     o_count
);
  logic [XLEN-1:0] r_pc_mem [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;
  // ready depends only on occupancy, so a full queue refuses a push even when popping
  assign o_in_ready  = r_count != (AW+1)'(DEPTH);
  assign o_out_valid = r_count != '0;
  assign o_out_pc    = o_out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign o_out_instr = o_out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
  assign w_push      = i_in_valid & o_in_ready & ~i_flush;
  assign w_pop       = o_out_valid & i_out_ready & ~i_flush;
  // entry contents need no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= i_in_pc;
      r_instr_mem[r_wr_ptr] <= i_in_instr;
    end
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;
  int n_cmp = 0;
  int n_err = 0;

  fetch_decode_queue #(.DEPTH(4), .AW(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .i_in_pc(in_pc), .i_in_instr(in_instr), .o_in_ready(in_ready),
    .i_flush(flush),
    .o_out_valid(out_valid), .o_out_pc(out_pc), .o_out_instr(out_instr), .i_out_ready(out_ready),
    .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hDEAD; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA0 + 32'(i);
      tick();
      n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_err++; $display("FAIL fill_head[%0d] got pc=%h v=%b want pc=0 v=1", i, out_pc, out_valid); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    in_pc = 32'd16; in_instr = 32'hA4;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_refuse_count got %0d want 4", count); end
    n_cmp++; if (out_pc !== 32'h0 || out_instr !== 32'hA0) begin n_err++; $display("FAIL fill_refuse_head got %h/%h want 0/a0", out_pc, out_instr); end
  endtask

  task automatic test_drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'hA0 + 32'(i))
        begin n_err++; $display("FAIL drain[%0d] got v=%b %h/%h want 1 %h/%h", i, out_valid, out_pc, out_instr, 4 * i, 32'hA0 + 32'(i)); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_empty got v=%b c=%0d want 0 0", out_valid, count); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_underflow got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'(4 * k); in_instr = 32'hB00 + 32'(k);
      if (k == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_start got v=%b want 0", out_valid); end
      end else begin
        n_cmp++; if (out_pc !== 32'(4 * (k - 1)) || out_instr !== 32'hB00 + 32'(k - 1) || count !== 3'd1)
          begin n_err++; $display("FAIL stream[%0d] got %h/%h c=%0d want %h/%h c=1", k, out_pc, out_instr, count, 4 * (k - 1), 32'hB00 + 32'(k - 1)); end
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_pc !== 32'd36 || count !== 3'd1) begin n_err++; $display("FAIL stream_last got %h c=%0d want 24 c=1", out_pc, count); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_end got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'd100 + 32'(4 * i); in_instr = 32'hC0 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", count); end
    flush = 1'b1; in_pc = 32'd40; in_instr = 32'hC40;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin n_err++; $display("FAIL flush_clear got c=%0d v=%b pc=%h want 0 0 0", count, out_valid, out_pc); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got v=%b pc=%h want 0", out_valid, out_pc); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'd200 + 32'(4 * i); in_instr = 32'hD0 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_pre got c=%0d r=%b want 4 0", count, in_ready); end
    in_pc = 32'd216; in_instr = 32'hD4; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_after got c=%0d r=%b want 3 1", count, in_ready); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (out_pc !== 32'd200 + 32'(4 * i) || out_instr !== 32'hD0 + 32'(i))
        begin n_err++; $display("FAIL fullpop_order[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, 200 + 4 * i, 32'hD0 + 32'(i)); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL fullpop_end got v=%b c=%0d want 0 0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'd300 + 32'(4 * i); in_instr = 32'hE0 + 32'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL midreset_pre got %0d want 2", count); end
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midreset got c=%0d v=%b r=%b want 0 0 1", count, out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_full_pop();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
